// File: rtl/ysyx_25060170_mem_resp.sv
// ---------------------------------------------------------------------------
// ysyx_25060170_mem_resp
//
// Single-outstanding memory responder with a programmable response delay.
// A request is accepted in IDLE, held in WAIT while the delay counter runs
// down, and presented in RESP until the initiator takes it.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid && ready. req_ready is high only in IDLE. rsp_valid,
// rsp_rdata and rsp_err stay constant in RESP until rsp_ready is seen.
//
// Parameters:
//   BASE_ADDR  - byte address of word 0
//   DEPTH_LOG2 - log2 of storage depth in 32-bit words
//   LATENCY    - accept-to-rsp_valid delay in cycles (1..15)
//
// Build option:
//   YSYX_25060170_MEM_RAND_DELAY_EN - when defined, each transaction's delay
//   comes from a 4-bit LFSR (x^4+x^3+1, seed 4'b1001, stepped once per
//   accept) and LATENCY is ignored.
//
// Ports:
//   clk        - clock, all state changes on rising edge
//   rst        - asynchronous active-low reset
//   req_valid  - request present          req_ready - request can be taken
//   req_addr   - byte address             req_wen   - 1 write / 0 read
//   req_wdata  - write data               req_wmask - byte-lane write enables
//   rsp_valid  - response present         rsp_ready - response taken
//   rsp_rdata  - read data (0 for writes and faults)
//   rsp_err    - address fault
//   dbg_state  - current FSM state (0 IDLE, 1 WAIT, 2 RESP)
// ---------------------------------------------------------------------------
module ysyx_25060170_mem_resp #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Out-of-range LATENCY values are clamped so the counter can never be
    // loaded with 0 and stall in WAIT.
    localparam int          LAT_CLAMP = (LATENCY < 1) ? 1 : ((LATENCY > 15) ? 15 : LATENCY);
    localparam logic [3:0]  LAT4      = 4'(LAT_CLAMP);

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wmask_q;
    logic                  wen_q;

    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic                  finish;
    logic                  fault;
    logic                  commit;
    logic [31:0]           offset;
    logic [DEPTH_LOG2-1:0] idx;
    logic [3:0]            delay_load;

    assign req_ready = (state == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign finish    = (state == S_WAIT) && (cnt == 4'd1);
    assign dbg_state = state;

    // Fault decode works on the latched address. The range test is done in
    // 64 bits so the bound 4<<DEPTH_LOG2 cannot wrap, and subtraction wraps
    // addresses below BASE_ADDR to large offsets so they fault too.
    assign offset = addr_q - BASE_ADDR;
    assign fault  = (addr_q[1:0] != 2'b00) ||
                    ({32'd0, offset} >= (64'd4 << DEPTH_LOG2));
    assign idx    = addr_q[DEPTH_LOG2+1:2];

    // Including rst keeps a write from landing on an edge that coincides
    // with reset assertion.
    assign commit = finish && wen_q && !fault && rst;

`ifdef YSYX_25060170_MEM_RAND_DELAY_EN
    logic [3:0] lfsr;

    // Fibonacci LFSR for x^4+x^3+1; never reaches zero from a nonzero seed,
    // so every delay is in 1..15. The current value is used by the accept
    // that steps it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 4'b1001;
        end else if (accept) begin
            lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
    end

    assign delay_load = lfsr;
`else
    assign delay_load = LAT4;
`endif

    // Control and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wmask_q   <= 4'd0;
            wen_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wmask_q <= req_wmask;
                        wen_q   <= req_wen;
                        cnt     <= delay_load;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        state     <= S_RESP;
                        cnt       <= 4'd0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= fault;
                        rsp_rdata <= (fault || wen_q) ? 32'd0 : mem[idx];
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    // Returning to IDLE here makes req_ready low on the
                    // completing edge, so the next accept is one edge later.
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; only enabled byte lanes are written.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25060170_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25060170_mem_resp
//
// Two responders share the request/response wires through a select: dut1
// uses LATENCY=1, dut4 uses LATENCY=4. Each has its own reset. Expected
// responses are pushed to exp_q when a request is accepted and popped when
// the response appears.
// ---------------------------------------------------------------------------
module tb_ysyx_25060170_mem_resp;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] SPAN = 32'h0000_1000;   // 1024 words

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1;
    logic rst4;
    logic sel;

    logic        req_valid;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        rsp_ready;

    logic        req_ready1, rsp_valid1, rsp_err1;
    logic [31:0] rsp_rdata1;
    logic [1:0]  st1;
    logic        req_ready4, rsp_valid4, rsp_err4;
    logic [31:0] rsp_rdata4;
    logic [1:0]  st4;

    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  st;

    assign req_ready = sel ? req_ready4 : req_ready1;
    assign rsp_valid = sel ? rsp_valid4 : rsp_valid1;
    assign rsp_err   = sel ? rsp_err4   : rsp_err1;
    assign rsp_rdata = sel ? rsp_rdata4 : rsp_rdata1;
    assign st        = sel ? st4        : st1;

    ysyx_25060170_mem_resp #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1),
        .req_valid(req_valid & ~sel), .req_ready(req_ready1),
        .req_addr(req_addr), .req_wen(req_wen),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready & ~sel),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .dbg_state(st1)
    );

    ysyx_25060170_mem_resp #(.LATENCY(4)) dut4 (
        .clk(clk), .rst(rst4),
        .req_valid(req_valid & sel), .req_ready(req_ready4),
        .req_addr(req_addr), .req_wen(req_wen),
        .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready & sel),
        .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4), .dbg_state(st4)
    );

    // ---------------- scoreboard / model ----------------
    int checks   = 0;
    int failures = 0;

    logic [32:0] exp_q[$];             // {err, rdata}
    logic [31:0] model_mem[int];
    logic [3:0]  lf1 = 4'b1001;
    logic [3:0]  lf4 = 4'b1001;

    logic        pend_valid;
    int          pend_key;
    logic [31:0] pend_wdata;
    logic [3:0]  pend_wmask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic is_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a - BASE) >= SPAN);
    endfunction

    function automatic int key_of(input logic s, input logic [31:0] a);
        return (s ? 4096 : 0) + int'((a - BASE) >> 2);
    endfunction

    function automatic logic [3:0] lfsr_next(input logic [3:0] v);
        return {v[2:0], v[3] ^ v[2]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic [32:0] exp, output int exp_lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("state_wait_after_accept", 32'(st), 32'd1);
        exp_q.push_back(exp);
        pend_valid = wen && !is_fault(addr);
        pend_key   = key_of(sel, addr);
        pend_wdata = wdata;
        pend_wmask = wmask;
`ifdef YSYX_25060170_MEM_RAND_DELAY_EN
        if (sel) begin
            exp_lat = int'(lf4);
            lf4 = lfsr_next(lf4);
        end else begin
            exp_lat = int'(lf1);
            lf1 = lfsr_next(lf1);
        end
`else
        exp_lat = sel ? 4 : 1;
`endif
    endtask

    // Waits for the response, checks latency/data, holds rsp_ready low for
    // 'hold' cycles, then completes. With keep_valid a read of BASE+0x10 is
    // already presented on the completing edge.
    task automatic collect(input int exp_lat, input int hold, input logic keep_valid);
        int lat;
        logic [32:0] e;
        logic [31:0] w;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!rsp_valid && lat < 40);
        e = exp_q.pop_front();
        chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        if (!rsp_valid) return;
        chk("latency", 32'(lat), 32'(exp_lat));
`ifdef YSYX_25060170_MEM_RAND_DELAY_EN
        chk("latency_range", 32'(lat >= 1 && lat <= 15), 32'd1);
`endif
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", 32'(rsp_err), 32'(e[32]));
        chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("hold%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("hold%0d_rdata", i), rsp_rdata, e[31:0]);
            chk($sformatf("hold%0d_err", i), 32'(rsp_err), 32'(e[32]));
            chk($sformatf("hold%0d_req_ready", i), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        if (keep_valid) begin
            req_valid = 1'b1;
            req_wen   = 1'b0;
            req_addr  = BASE + 32'h10;
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        if (pend_valid) begin
            w = model_mem.exists(pend_key) ? model_mem[pend_key] : 32'd0;
            for (int b = 0; b < 4; b++)
                if (pend_wmask[b]) w[8*b +: 8] = pend_wdata[8*b +: 8];
            model_mem[pend_key] = w;
        end
        pend_valid = 1'b0;
        if (keep_valid) begin
            chk("no_accept_on_completion_edge", 32'(st), 32'd0);
        end else begin
            @(negedge clk);
            chk("rsp_valid_after_done", 32'(rsp_valid), 32'd0);
            chk("req_ready_after_done", 32'(req_ready), 32'd1);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          hold;
    } vec_t;

    vec_t vecs[16];

    initial begin
        automatic int lat;
        automatic logic [31:0] a;
        automatic logic [31:0] d;
        automatic logic [3:0]  m;
        automatic logic        w;
        automatic logic [32:0] e;
        automatic int          k;

        vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0, 0};
        vecs[1]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0, 0};
        vecs[2]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'h5, 32'h0000_0000, 1'b0, 1};
        vecs[3]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'hDE22_BE44, 1'b0, 0};
        vecs[4]  = '{1'b0, 32'h8000_0002, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1, 0};
        vecs[5]  = '{1'b0, 32'h7FFF_FFFC, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1, 0};
        vecs[6]  = '{1'b1, 32'h8000_0012, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1, 0};
        vecs[7]  = '{1'b1, 32'h7FFF_FFF0, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1, 0};
        vecs[8]  = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'hDE22_BE44, 1'b0, 2};
        vecs[9]  = '{1'b1, 32'h8000_0FFC, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0, 0};
        vecs[10] = '{1'b0, 32'h8000_0FFC, 32'h0000_0000, 4'h0, 32'hA5A5_A5A5, 1'b0, 0};
        vecs[11] = '{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1, 0};
        vecs[12] = '{1'b1, 32'h8000_0FFC, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b0, 0};
        vecs[13] = '{1'b0, 32'h8000_0FFC, 32'hFFFF_FFFF, 4'hF, 32'hA5A5_A5A5, 1'b0, 0};
        vecs[14] = '{1'b1, 32'h8000_0010, 32'h7700_0000, 4'h8, 32'h0000_0000, 1'b0, 0};
        vecs[15] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'h0, 32'h7722_BE44, 1'b0, 5};

        // ---- reset ----
        sel = 1'b0; rst1 = 1'b0; rst4 = 1'b0;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_wmask = 4'd0; rsp_ready = 1'b0;
        pend_valid = 1'b0; pend_key = 0; pend_wdata = 32'd0; pend_wmask = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid1", 32'(rsp_valid1), 32'd0);
        chk("reset_rsp_rdata1", rsp_rdata1, 32'd0);
        chk("reset_rsp_err1", 32'(rsp_err1), 32'd0);
        chk("reset_state1", 32'(st1), 32'd0);
        chk("reset_rsp_valid4", 32'(rsp_valid4), 32'd0);
        rst1 = 1'b1; rst4 = 1'b1;
        #1;
        chk("req_ready1_after_reset", 32'(req_ready1), 32'd1);
        chk("req_ready4_after_reset", 32'(req_ready4), 32'd1);

        // ---- table phase on dut1 ----
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
                  {vecs[i].exp_err, vecs[i].exp_rdata}, lat);
            collect(lat, vecs[i].hold, 1'b0);
        end

        // ---- no accept on the completing edge ----
        issue(1'b0, BASE + 32'h10, 32'd0, 4'h0, {1'b0, 32'h7722_BE44}, lat);
        collect(lat, 5, 1'b1);
        issue(1'b0, BASE + 32'h10, 32'd0, 4'h0, {1'b0, 32'h7722_BE44}, lat);
        collect(lat, 0, 1'b0);

        // ---- 20 back-to-back reads ----
        for (int i = 0; i < 20; i++) begin
            issue(1'b0, BASE + 32'h10, 32'd0, 4'h0, {1'b0, 32'h7722_BE44}, lat);
            collect(lat, 0, 1'b0);
        end

        // ---- async reset while dut1 is in RESP ----
        issue(1'b0, BASE + 32'h10, 32'd0, 4'h0, {1'b0, 32'h7722_BE44}, lat);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 40);
        chk("resp_before_reset", 32'(rsp_valid), 32'd1);
        #2 rst1 = 1'b0;
        #1;
        chk("reset_in_resp_valid", 32'(rsp_valid1), 32'd0);
        chk("reset_in_resp_rdata", rsp_rdata1, 32'd0);
        chk("reset_in_resp_state", 32'(st1), 32'd0);
        void'(exp_q.pop_front());
        pend_valid = 1'b0;
        lf1 = 4'b1001;
        @(negedge clk);
        rst1 = 1'b1;
        issue(1'b0, BASE + 32'h10, 32'd0, 4'h0, {1'b0, 32'h7722_BE44}, lat);
        collect(lat, 0, 1'b0);

        // ---- LATENCY=4: reset two cycles into WAIT drops the write ----
        sel = 1'b1;
        issue(1'b1, BASE + 32'h20, 32'hCAFE_F00D, 4'hF, 33'd0, lat);
        collect(lat, 0, 1'b0);
        issue(1'b1, BASE + 32'h20, 32'h0BAD_BEEF, 4'hF, 33'd0, lat);
        @(posedge clk);
        @(posedge clk);
        #1 rst4 = 1'b0;
        #1;
        chk("lat4_reset_state", 32'(st4), 32'd0);
        chk("lat4_reset_rsp_valid", 32'(rsp_valid4), 32'd0);
        chk("lat4_reset_rsp_rdata", rsp_rdata4, 32'd0);
        chk("lat4_reset_rsp_err", 32'(rsp_err4), 32'd0);
        void'(exp_q.pop_back());
        pend_valid = 1'b0;
        lf4 = 4'b1001;
        @(negedge clk);
        rst4 = 1'b1;
        #1;
        chk("lat4_req_ready_after_reset", 32'(req_ready4), 32'd1);
        issue(1'b0, BASE + 32'h20, 32'd0, 4'h0, {1'b0, 32'hCAFE_F00D}, lat);
        collect(lat, 0, 1'b0);
        sel = 1'b0;

        // ---- random phase on dut1 against the model ----
        for (int i = 0; i < 8; i++) begin
            a = BASE + 32'h100 + 32'(4 * i);
            d = $urandom;
            issue(1'b1, a, d, 4'hF, 33'd0, lat);
            collect(lat, 0, 1'b0);
        end
        for (int i = 0; i < 30; i++) begin
            a = BASE + 32'h100 + 32'(4 * $urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) a = a + 32'($urandom_range(1, 3));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            m = 4'($urandom_range(0, 15));
            if (is_fault(a))  e = {1'b1, 32'd0};
            else if (w)       e = 33'd0;
            else              e = {1'b0, model_mem[key_of(1'b0, a)]};
            issue(w, a, d, m, e, lat);
            collect(lat, $urandom_range(0, 2), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
